// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter, issues in-order word fetches to instruction memory,
// buffers returned words in a prefetch FIFO and hands them downstream.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   imem_req_valid_o/ready_i/addr_o     fetch request channel
//   imem_rsp_valid_i/data_i             in-order responses, no backpressure
//   redirect_i, redirect_pc_i           branch redirect (flush + refetch)
//   instr_valid_o/ready_i               downstream handshake
//   instr_o, pc_o, pc_incr_o            head instruction, its PC, PC + 4
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_incr_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [PW-1:0] r_fifo_rd;
    logic [PW-1:0] r_fifo_wr;
    logic [CW-1:0] r_fifo_cnt;
    logic [31:0]   r_pcq        [DEPTH];
    logic [PW-1:0] r_pcq_rd;
    logic [PW-1:0] r_pcq_wr;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;

    logic          w_pop;
    logic [CW:0]   w_occ;
    logic          w_req_fire;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic [1:0]    w_unused_rpc_lsb;

    assign w_unused_rpc_lsb = redirect_pc_i[1:0];

    assign instr_valid_o = (r_fifo_cnt != '0);
    assign instr_o       = instr_valid_o ? r_fifo_instr[r_fifo_rd] : 32'h0000_0013;
    assign pc_o          = instr_valid_o ? r_fifo_pc[r_fifo_rd] : 32'h0000_0000;
    assign pc_incr_o     = pc_o + 32'd4;

    assign w_pop = instr_valid_o & instr_ready_i;

    // Every slot is reserved from request issue until the word leaves the FIFO;
    // responses still owed to a flushed stream also hold a slot until they arrive.
    assign w_occ = {1'b0, r_inflight} + {1'b0, r_drop_cnt} + {1'b0, r_fifo_cnt}
                 - {{CW{1'b0}}, w_pop};

    assign imem_req_valid_o = rst_n & ~redirect_i & (w_occ < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = r_fetch_pc;
    assign w_req_fire       = imem_req_valid_o & imem_req_ready_i;

    // Stale responses (older stream, or arriving during a redirect) are dropped.
    assign w_rsp_drop = imem_rsp_valid_i & (redirect_i | (r_drop_cnt != '0));
    assign w_rsp_live = imem_rsp_valid_i & ~w_rsp_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_fifo_cnt <= '0;
            r_pcq_rd   <= '0;
            r_pcq_wr   <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            r_fifo_rd  <= '0;
            r_fifo_wr  <= '0;
            r_fifo_cnt <= '0;
            r_pcq_rd   <= '0;
            r_pcq_wr   <= '0;
            r_inflight <= '0;
            // A response in this cycle is already accounted for as dropped.
            r_drop_cnt <= r_drop_cnt + r_inflight - CW'(imem_rsp_valid_i);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_pcq_wr   <= r_pcq_wr + PW'(1);
            end
            if (w_rsp_live) begin
                r_pcq_rd  <= r_pcq_rd + PW'(1);
                r_fifo_wr <= r_fifo_wr + PW'(1);
            end
            if (w_pop) begin
                r_fifo_rd <= r_fifo_rd + PW'(1);
            end
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + CW'(w_rsp_live) - CW'(w_pop);
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_live);
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_pcq[r_pcq_wr] <= r_fetch_pc;
        end
        if (w_rsp_live) begin
            r_fifo_pc[r_fifo_wr]    <= r_pcq[r_pcq_rd];
            r_fifo_instr[r_fifo_wr] <= imem_rsp_data_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rsp_live && (r_fifo_cnt == CW'(DEPTH))));

endmodule
